// File: rtl/noc_arb_pkg.sv
// Shared NoC arbitration types and index-width helpers. The packetizer and depacketizer
// blocks use the same VC and source index widths.
package noc_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits for a count of one or two.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int NOC_NUM_VC  = 2;
    localparam int NOC_NUM_SRC = 4;
    localparam int NOC_VC_W    = clog2_min1(NOC_NUM_VC);
    localparam int NOC_SRC_W   = clog2_min1(NOC_NUM_SRC);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first asserted request strictly after i_ptr
// wins, wrapping from N-1 back to 0. Produces a one-hot grant, its index, and an any-flag.
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand  = '0;
        o_idx = '0;
        o_any = 1'b0;
        // Scan from the farthest candidate to the nearest so the nearest one is written last.
        for (int i = N; i >= 1; i--) begin
            cand = IDX_W'((int'(i_ptr) + i) % N);
            if (i_req[cand]) begin
                o_idx = cand;
                o_any = 1'b1;
            end
        end
        o_grant = '0;
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Shares one NoC injection port among NUM_REQ sources: round-robin, packet-granular grants
// with a burst limit, per-source VC tagging, a registered output stage and sent counters.
module noc_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 500,
    parameter int DEST_WIDTH = 4,
    parameter int NUM_VC     = 2,
    parameter logic [0:NUM_REQ-1][clog2_min1(NUM_VC)-1:0] ASSIGNED_VC = '0,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                                   clk_rtl,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     i_data_in,
    input  logic [NUM_REQ-1:0][DEST_WIDTH-1:0]     i_dest_in,
    input  logic [NUM_REQ-1:0]                     i_valid_in,
    output logic [NUM_REQ-1:0]                     i_ready_out,
    output logic [DATA_WIDTH-1:0]                  o_data_out,
    output logic [DEST_WIDTH-1:0]                  o_dest_out,
    output logic [clog2_min1(NUM_VC)-1:0]          o_vc_out,
    output logic [clog2_min1(NUM_REQ)-1:0]         o_src_out,
    output logic                                   o_valid_out,
    input  logic                                   o_ready_in,
    output logic [NUM_REQ-1:0][CNT_WIDTH-1:0]      o_sent_count,
    output arb_state_t                             o_dbg_state
);

    localparam int VC_W    = clog2_min1(NUM_VC);
    localparam int SRC_W   = clog2_min1(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    // Handshakes on both sides transfer when valid and ready are high at posedge clk_rtl;
    // valid may only fall after a transfer and the payload is held while valid & !ready.

    arb_state_t                           state_q, state_d;
    logic [SRC_W-1:0]                     ptr_q, ptr_d;
    logic [SRC_W-1:0]                     owner_q, owner_d;
    logic [BURST_W-1:0]                   burst_q, burst_d;
    logic                                 valid_q, valid_d;
    logic [DATA_WIDTH-1:0]                data_q, data_d;
    logic [DEST_WIDTH-1:0]                dest_q, dest_d;
    logic [VC_W-1:0]                      vc_q, vc_d;
    logic [SRC_W-1:0]                     src_q, src_d;
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic                 load_en;
    logic                 hold_ok;
    logic                 grant_en;
    logic [SRC_W-1:0]     winner;
    logic [NUM_REQ-1:0]   rr_grant;
    logic [SRC_W-1:0]     rr_idx;
    logic                 rr_any;
    logic [NUM_REQ-1:0]   win_onehot;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_rr_pick (
        .i_req   (i_valid_in),
        .i_ptr   (ptr_q),
        .o_grant (rr_grant),
        .o_idx   (rr_idx),
        .o_any   (rr_any)
    );

    assign load_en  = !valid_q || o_ready_in;
    assign hold_ok  = (state_q == ARB_HOLD) && i_valid_in[owner_q] &&
                      (burst_q < BURST_W'(MAX_BURST));
    assign grant_en = load_en && rr_any;
    assign winner   = hold_ok ? owner_q : rr_idx;

    always_comb begin
        win_onehot = rr_grant;
        if (hold_ok) begin
            win_onehot          = '0;
            win_onehot[owner_q] = 1'b1;
        end
    end

    assign i_ready_out = grant_en ? win_onehot : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        valid_d = valid_q;
        data_d  = data_q;
        dest_d  = dest_q;
        vc_d    = vc_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        if (grant_en) begin
            state_d = ARB_HOLD;
            if (hold_ok) begin
                burst_d = burst_q + BURST_W'(1);
            end else begin
                // A fresh round-robin win, possibly the same owner after hitting the limit.
                ptr_d   = rr_idx;
                owner_d = rr_idx;
                burst_d = BURST_W'(1);
            end
            valid_d = 1'b1;
            data_d  = i_data_in[winner];
            dest_d  = i_dest_in[winner];
            vc_d    = ASSIGNED_VC[winner];
            src_d   = winner;
        end else begin
            if (load_en && (state_q == ARB_HOLD)) begin
                state_d = ARB_IDLE;
            end
            if (o_ready_in) begin
                valid_d = 1'b0;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_valid_in[k] && i_ready_out[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_rtl or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= SRC_W'(NUM_REQ - 1);
            owner_q <= '0;
            burst_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
            vc_q    <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            vc_q    <= vc_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_data_out   = data_q;
    assign o_dest_out   = dest_q;
    assign o_vc_out     = vc_q;
    assign o_src_out    = src_q;
    assign o_valid_out  = valid_q;
    assign o_sent_count = cnt_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter: per-scenario tasks drive requester traffic and
// compare the output stream against hand-derived source orders and packet contents.
`timescale 1ns/1ps
module tb_noc_port_arbiter;
    import noc_arb_pkg::*;

    localparam int NR  = 4;
    localparam int DW  = 500;
    localparam int DSW = 4;
    localparam int CW  = 32;
    // VC per requester 0..3 is 0,1,0,1 (bit k holds requester k).
    localparam logic [3:0] VC_TAB = 4'b1010;

    logic                     clk_rtl = 1'b0;
    logic                     reset   = 1'b1;
    logic [NR-1:0][DW-1:0]    i_data_in;
    logic [NR-1:0][DSW-1:0]   i_dest_in;
    logic [NR-1:0]            i_valid_in;
    logic [NR-1:0]            i_ready_out;
    logic [DW-1:0]            o_data_out;
    logic [DSW-1:0]           o_dest_out;
    logic [0:0]               o_vc_out;
    logic [1:0]               o_src_out;
    logic                     o_valid_out;
    logic                     o_ready_in;
    logic [NR-1:0][CW-1:0]    o_sent_count;
    arb_state_t               o_dbg_state;

    noc_port_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .DEST_WIDTH  (DSW),
        .NUM_VC      (2),
        .ASSIGNED_VC (4'b0101),
        .MAX_BURST   (4),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_rtl      (clk_rtl),
        .reset        (reset),
        .i_data_in    (i_data_in),
        .i_dest_in    (i_dest_in),
        .i_valid_in   (i_valid_in),
        .i_ready_out  (i_ready_out),
        .o_data_out   (o_data_out),
        .o_dest_out   (o_dest_out),
        .o_vc_out     (o_vc_out),
        .o_src_out    (o_src_out),
        .o_valid_out  (o_valid_out),
        .o_ready_in   (o_ready_in),
        .o_sent_count (o_sent_count),
        .o_dbg_state  (o_dbg_state)
    );

    always #5 clk_rtl = ~clk_rtl;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int pend_n [NR];
    int sent_n [NR];

    logic [1:0]     exp_src_q[$];
    logic [1:0]     obs_src_q[$];
    logic [0:0]     obs_vc_q[$];
    logic [DSW-1:0] obs_dest_q[$];
    logic [DW-1:0]  obs_data_q[$];
    int             obs_cyc_q[$];

    function automatic logic [DW-1:0] make_data(input int k, input int n);
        logic [DW-1:0] d;
        d            = '0;
        d[DW-1 -: 8] = 8'(8'hA0 + k);
        d[31:0]      = {8'(k), 8'h5A, 16'(n)};
        return d;
    endfunction

    function automatic logic [DSW-1:0] make_dest(input int k, input int n);
        return DSW'((k * 5 + n) % 16);
    endfunction

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            i_valid_in[k] = (pend_n[k] > 0);
            i_data_in[k]  = make_data(k, sent_n[k]);
            i_dest_in[k]  = make_dest(k, sent_n[k]);
        end
    endtask

    // One clock: record what transfers at the coming edge, then present new inputs after it.
    task automatic tick();
        @(negedge clk_rtl);
        for (int k = 0; k < NR; k++) begin
            if (i_valid_in[k] && i_ready_out[k]) begin
                pend_n[k]--;
                sent_n[k]++;
            end
        end
        if (o_valid_out && o_ready_in) begin
            obs_src_q.push_back(o_src_out);
            obs_vc_q.push_back(o_vc_out);
            obs_dest_q.push_back(o_dest_out);
            obs_data_q.push_back(o_data_out);
            obs_cyc_q.push_back(cyc);
        end
        @(posedge clk_rtl);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run_until(input int n, input int budget);
        int g;
        g = 0;
        while (obs_src_q.size() < n && g < budget) begin
            tick();
            g++;
        end
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        o_ready_in = 1'b1;
        for (int k = 0; k < NR; k++) begin
            pend_n[k] = 0;
            sent_n[k] = 0;
        end
        exp_src_q.delete();
        obs_src_q.delete();
        obs_vc_q.delete();
        obs_dest_q.delete();
        obs_data_q.delete();
        obs_cyc_q.delete();
        drive();
        repeat (2) @(posedge clk_rtl);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (o_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", o_valid_out); end
        n_checks++; if (o_data_out !== '0) begin n_err++; $display("FAIL rst_data: got %h expected 0", o_data_out); end
        n_checks++; if (o_dest_out !== '0) begin n_err++; $display("FAIL rst_dest: got %h expected 0", o_dest_out); end
        n_checks++; if (o_vc_out !== '0) begin n_err++; $display("FAIL rst_vc: got %h expected 0", o_vc_out); end
        n_checks++; if (o_src_out !== '0) begin n_err++; $display("FAIL rst_src: got %h expected 0", o_src_out); end
        n_checks++; if (o_sent_count !== '0) begin n_err++; $display("FAIL rst_counts: got %h expected 0", o_sent_count); end
        n_checks++; if (o_dbg_state !== ARB_IDLE) begin n_err++; $display("FAIL rst_state: got %0d expected %0d", o_dbg_state, ARB_IDLE); end
        n_checks++; if (i_ready_out !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b expected 0000", i_ready_out); end
    endtask

    task automatic test_single_req();
        int seen [NR];
        apply_reset();
        pend_n[0] = 10;
        drive();
        #1;
        n_checks++; if (i_ready_out !== 4'b0001) begin n_err++; $display("FAIL t1_first_ready: got %b expected 0001", i_ready_out); end
        n_checks++; if (o_valid_out !== 1'b0) begin n_err++; $display("FAIL t1_pre_valid: got %b expected 0", o_valid_out); end
        tick();
        n_checks++;
        if ({o_valid_out, o_src_out, o_data_out} !== {1'b1, 2'd0, make_data(0, 0)}) begin
            n_err++; $display("FAIL t1_latency: got v=%b src=%0d data=%h expected v=1 src=0 data=%h", o_valid_out, o_src_out, o_data_out, make_data(0, 0));
        end
        for (int i = 0; i < 10; i++) exp_src_q.push_back(2'd0);
        run_until(10, 40);
        tick();
        n_checks++; if (obs_src_q.size() != 10) begin n_err++; $display("FAIL t1_count_out: got %0d expected 10", obs_src_q.size()); end
        seen = '{default: 0};
        for (int i = 0; i < obs_src_q.size() && i < exp_src_q.size(); i++) begin
            logic [1:0] es;
            es = exp_src_q[i];
            n_checks++; if (obs_src_q[i] !== es) begin n_err++; $display("FAIL t1_src[%0d]: got %0d expected %0d", i, obs_src_q[i], es); end
            n_checks++;
            if ({obs_vc_q[i], obs_dest_q[i], obs_data_q[i]} !== {VC_TAB[es], make_dest(es, seen[es]), make_data(es, seen[es])}) begin
                n_err++; $display("FAIL t1_pkt[%0d]: got vc=%0d dest=%0d data=%h expected vc=%0d dest=%0d data=%h", i, obs_vc_q[i], obs_dest_q[i], obs_data_q[i], VC_TAB[es], make_dest(es, seen[es]), make_data(es, seen[es]));
            end
            seen[es]++;
        end
        if (obs_cyc_q.size() == 10) begin
            n_checks++; if (obs_cyc_q[9] - obs_cyc_q[0] != 9) begin n_err++; $display("FAIL t1_b2b: got span %0d expected 9", obs_cyc_q[9] - obs_cyc_q[0]); end
        end
        n_checks++; if (o_sent_count !== {32'd0, 32'd0, 32'd0, 32'd10}) begin n_err++; $display("FAIL t1_counts: got %h expected cnt0=10 others 0", o_sent_count); end
        n_checks++; if ({o_valid_out, o_dbg_state} !== {1'b0, ARB_IDLE}) begin n_err++; $display("FAIL t1_drain: got v=%b st=%0d expected v=0 st=IDLE", o_valid_out, o_dbg_state); end
    endtask

    task automatic test_all_burst(input bit with_stall);
        int seen [NR];
        apply_reset();
        for (int k = 0; k < NR; k++) pend_n[k] = 8;
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NR; s++)
                for (int b = 0; b < 4; b++) exp_src_q.push_back(2'(s));
        drive();
        if (with_stall) begin
            run_until(6, 30);
            n_checks++;
            if ({o_valid_out, o_src_out, o_data_out} !== {1'b1, 2'd1, make_data(1, 2)}) begin
                n_err++; $display("FAIL t4_pre_stall: got v=%b src=%0d data=%h expected v=1 src=1 data=%h", o_valid_out, o_src_out, o_data_out, make_data(1, 2));
            end
            o_ready_in = 1'b0;
            for (int c = 0; c < 5; c++) begin
                tick();
                n_checks++;
                if ({o_valid_out, i_ready_out, o_data_out} !== {1'b1, 4'b0000, make_data(1, 2)}) begin
                    n_err++; $display("FAIL t4_stall[%0d]: got v=%b rdy=%b data=%h expected v=1 rdy=0000 data=%h", c, o_valid_out, i_ready_out, o_data_out, make_data(1, 2));
                end
            end
            o_ready_in = 1'b1;
        end
        run_until(32, 80);
        tick();
        n_checks++; if (obs_src_q.size() != 32) begin n_err++; $display("FAIL t%0d_count_out: got %0d expected 32", with_stall ? 4 : 2, obs_src_q.size()); end
        seen = '{default: 0};
        for (int i = 0; i < obs_src_q.size() && i < exp_src_q.size(); i++) begin
            logic [1:0] es;
            es = exp_src_q[i];
            n_checks++; if (obs_src_q[i] !== es) begin n_err++; $display("FAIL t%0d_src[%0d]: got %0d expected %0d", with_stall ? 4 : 2, i, obs_src_q[i], es); end
            n_checks++;
            if ({obs_vc_q[i], obs_dest_q[i], obs_data_q[i]} !== {VC_TAB[es], make_dest(es, seen[es]), make_data(es, seen[es])}) begin
                n_err++; $display("FAIL t%0d_pkt[%0d]: got vc=%0d dest=%0d data=%h expected vc=%0d dest=%0d data=%h", with_stall ? 4 : 2, i, obs_vc_q[i], obs_dest_q[i], obs_data_q[i], VC_TAB[es], make_dest(es, seen[es]), make_data(es, seen[es]));
            end
            seen[es]++;
        end
        n_checks++; if (o_sent_count !== {32'd8, 32'd8, 32'd8, 32'd8}) begin n_err++; $display("FAIL t%0d_counts: got %h expected all 8", with_stall ? 4 : 2, o_sent_count); end
    endtask

    task automatic test_back_to_back();
        int seen [NR];
        apply_reset();
        pend_n[2] = 12;
        for (int i = 0; i < 12; i++) exp_src_q.push_back(2'd2);
        drive();
        run_until(12, 40);
        tick();
        n_checks++; if (obs_src_q.size() != 12) begin n_err++; $display("FAIL t3_count_out: got %0d expected 12", obs_src_q.size()); end
        seen = '{default: 0};
        for (int i = 0; i < obs_src_q.size() && i < exp_src_q.size(); i++) begin
            logic [1:0] es;
            es = exp_src_q[i];
            n_checks++; if (obs_src_q[i] !== es) begin n_err++; $display("FAIL t3_src[%0d]: got %0d expected %0d", i, obs_src_q[i], es); end
            n_checks++;
            if ({obs_vc_q[i], obs_dest_q[i], obs_data_q[i]} !== {VC_TAB[es], make_dest(es, seen[es]), make_data(es, seen[es])}) begin
                n_err++; $display("FAIL t3_pkt[%0d]: got vc=%0d dest=%0d data=%h expected vc=%0d dest=%0d data=%h", i, obs_vc_q[i], obs_dest_q[i], obs_data_q[i], VC_TAB[es], make_dest(es, seen[es]), make_data(es, seen[es]));
            end
            seen[es]++;
        end
        if (obs_cyc_q.size() == 12) begin
            n_checks++; if (obs_cyc_q[11] - obs_cyc_q[0] != 11) begin n_err++; $display("FAIL t3_b2b: got span %0d expected 11", obs_cyc_q[11] - obs_cyc_q[0]); end
        end
        n_checks++; if (o_sent_count !== {32'd0, 32'd12, 32'd0, 32'd0}) begin n_err++; $display("FAIL t3_counts: got %h expected cnt2=12 others 0", o_sent_count); end
    endtask

    task automatic test_vc_tag();
        logic [1:0] exp_tab [6];
        int seen [NR];
        apply_reset();
        pend_n[0] = 1;
        pend_n[1] = 2;
        pend_n[2] = 1;
        pend_n[3] = 2;
        exp_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 6; i++) exp_src_q.push_back(exp_tab[i]);
        drive();
        run_until(6, 30);
        n_checks++; if (obs_src_q.size() != 6) begin n_err++; $display("FAIL t5_count_out: got %0d expected 6", obs_src_q.size()); end
        seen = '{default: 0};
        for (int i = 0; i < obs_src_q.size() && i < exp_src_q.size(); i++) begin
            logic [1:0] es;
            es = exp_src_q[i];
            n_checks++; if (obs_src_q[i] !== es) begin n_err++; $display("FAIL t5_src[%0d]: got %0d expected %0d", i, obs_src_q[i], es); end
            n_checks++;
            if ({obs_vc_q[i], obs_dest_q[i], obs_data_q[i]} !== {VC_TAB[es], make_dest(es, seen[es]), make_data(es, seen[es])}) begin
                n_err++; $display("FAIL t5_pkt[%0d]: got vc=%0d dest=%0d data=%h expected vc=%0d dest=%0d data=%h", i, obs_vc_q[i], obs_dest_q[i], obs_data_q[i], VC_TAB[es], make_dest(es, seen[es]), make_data(es, seen[es]));
            end
            seen[es]++;
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        pend_n[3] = 5;
        drive();
        tick();
        tick();
        n_checks++;
        if ({o_valid_out, o_dbg_state, o_src_out} !== {1'b1, ARB_HOLD, 2'd3}) begin
            n_err++; $display("FAIL t6_setup: got v=%b st=%0d src=%0d expected v=1 st=HOLD src=3", o_valid_out, o_dbg_state, o_src_out);
        end
        reset = 1'b1;
        #1;
        n_checks++; if (o_valid_out !== 1'b0) begin n_err++; $display("FAIL t6_valid_drop: got %b expected 0", o_valid_out); end
        n_checks++; if (o_sent_count !== '0) begin n_err++; $display("FAIL t6_counts: got %h expected 0", o_sent_count); end
        n_checks++; if ({o_dbg_state, o_src_out} !== {ARB_IDLE, 2'd0}) begin n_err++; $display("FAIL t6_state: got st=%0d src=%0d expected st=IDLE src=0", o_dbg_state, o_src_out); end
        apply_reset();
        for (int k = 0; k < NR; k++) begin
            pend_n[k] = 1;
            exp_src_q.push_back(2'(k));
        end
        drive();
        #1;
        n_checks++; if (i_ready_out !== 4'b0001) begin n_err++; $display("FAIL t6_first_grant: got %b expected 0001", i_ready_out); end
        run_until(4, 20);
        n_checks++; if (obs_src_q.size() != 4) begin n_err++; $display("FAIL t6_count_out: got %0d expected 4", obs_src_q.size()); end
        for (int i = 0; i < obs_src_q.size() && i < exp_src_q.size(); i++) begin
            n_checks++; if (obs_src_q[i] !== exp_src_q[i]) begin n_err++; $display("FAIL t6_src[%0d]: got %0d expected %0d", i, obs_src_q[i], exp_src_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_all_burst(1'b0);
        test_back_to_back();
        test_all_burst(1'b1);
        test_vc_tag();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
